// File: rtl/router_pkg.sv
// Shared constants and helpers for the router address-decode / channel-supervision slice.
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;

  // Timer width that never collapses to zero bits for tiny timeouts.
  function automatic int timer_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/router_stall_timer.sv
// Per-channel stall supervisor: pulses soft_reset for one cycle after TIMEOUT
// consecutive edges with data valid and not read.
module router_stall_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int              TW   = timer_width(TIMEOUT);
  localparam logic [TW-1:0]   LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      timer      <= '0;
      soft_reset <= 1'b0;
    end else if (timer == LAST) begin
      timer      <= '0;
      soft_reset <= 1'b1;
    end else begin
      timer      <= timer + 1'b1;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Router address latch/decode plus per-channel valid and stall supervision
// for NUM_CH output FIFOs.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  // One extra bit so NUM_CH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_CH_A = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] int_addr;
  logic              addr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_addr <= '0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      int_addr <= data_in;
      addr_err <= ({1'b0, data_in} >= NUM_CH_A);
    end
  end

  assign addr_valid = ({1'b0, int_addr} < NUM_CH_A);

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_valid && int_addr == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_stall_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .vld        (vld_out[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised address-decode and channel-supervision block for the router. It sits between the router FSM/register and NUM_CH output FIFOs. It latches the destination address, steers write enables and selects the FIFO full flag for that address. For every channel it drives valid-out from FIFO emptiness and issues a one-cycle soft reset when a channel has held valid data unread for TIMEOUT consecutive cycles. It adds three things over the fixed 3-channel version: a parametric channel count, a parametric timeout, and address-error flagging.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, width of the address field taken from data_in; must satisfy 2**ADDR_W >= NUM_CH
TIMEOUT, 30, number of consecutive unread-valid cycles before soft reset (>= 2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
detect_add  in  1  address byte present on data_in this cycle
write_enb_reg  in  1  FSM requests a write into the selected FIFO
data_in  in  ADDR_W  address field of the header byte
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
read_enb  in  NUM_CH  per-FIFO read enables from the destination side
write_enb  out  NUM_CH  one-hot write enable to the selected FIFO
fifo_full  out  1  full flag of the selected FIFO
vld_out  out  NUM_CH  per-channel data-available flags
soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush request
addr_err  out  1  last latched address is not a valid channel

Behaviour:
- Reset: clk is a single clock domain. rst is asynchronous and active-high. While rst is asserted, all registers clear immediately: int_addr=0, addr_err=0, every timer=0, soft_reset=0. Combinational outputs then follow the cleared state. Reset applied mid-stall discards the accumulated count.
- Address latch: at a clk edge with detect_add=1, int_addr <= data_in. At the same edge, addr_err <= (data_in >= NUM_CH). Both registers hold otherwise.
- addr_valid = (int_addr < NUM_CH), combinational.
- write_enb (combinational): bit i = write_enb_reg & addr_valid & (int_addr==i). The output is all-zero whenever write_enb_reg=0 or the address is invalid. No latches are permitted.
- fifo_full (combinational) = full[int_addr] when addr_valid, else 0.
- Write latency: detect_add and write_enb_reg asserted in the same cycle drive the previously latched address. The new address takes effect the cycle after detect_add.
- vld_out[i] = ~empty[i], combinational.
- Stall timer, per channel i, width $clog2(TIMEOUT), evaluated at each edge:
  - if vld_out[i]=0 or read_enb[i]=1: timer<=0, soft_reset[i]<=0
  - else if timer==TIMEOUT-1: timer<=0, soft_reset[i]<=1
  - else: timer<=timer+1, soft_reset[i]<=0
- Soft-reset timing: soft_reset[i] rises after the TIMEOUT-th consecutive edge sampling vld=1/read=0 and lasts exactly one cycle. A continuing stall produces another pulse every TIMEOUT cycles.
- A read, or the FIFO emptying, on any cycle restarts the count from zero. Channels are fully independent, and simultaneous timeouts on several channels each pulse.
- The timer never exceeds TIMEOUT-1. There is no wrap beyond that value.

Decomposition:
- Shared package router_pkg holds the constants NUM_CH_DEF=3, ADDR_W_DEF=2, TIMEOUT_DEF=30 and a function clog2-safe timer width.
- One sub-module, router_stall_timer (params TIMEOUT; ports clk, rst, vld, rd, soft_reset), instantiated NUM_CH times in a generate loop.
- Address latch and decode stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> soft_reset=0, addr_err=0, and write_enb=0 immediately, before the next clk edge.
- Address decode: NUM_CH=3, detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100 and fifo_full tracks full[2]. data_in=3 -> addr_err=1, write_enb=000, fifo_full=0.
- Timeout: empty[0]=0, read_enb[0]=0 held -> soft_reset[0]=1 for exactly one cycle after the 30th edge, and again after the 60th.
- Read restarts count: stall 29 cycles, pulse read_enb[1] for one cycle, stall again -> no pulse until 30 further stalled edges.
- Parameter sweep: NUM_CH=5, ADDR_W=3, TIMEOUT=4; stall channels 0 and 4 together -> both pulse on the same cycle after the 4th edge; address 5..7 -> addr_err=1.
